// File: rtl/psk_symbol_mapper.sv
// Serial-bit to QPSK/8-PSK Gray-mapped I/Q symbol source with valid/ready output.
// Optional internal PRBS-9 bit source enabled by defining PSK_MAPPER_PRBS_SRC_EN.
module psk_symbol_mapper #(
    parameter int unsigned DATA_WIDTH = 10,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [2:0]                   mode_i,
    input  logic                         enable_i,
    input  logic                         bit_i,
    input  logic                         bit_val_i,
    output logic                         bit_rdy_o,
    output logic signed [DATA_WIDTH-1:0] I_data_o,
    output logic signed [DATA_WIDTH-1:0] Q_data_o,
    output logic                         data_val_o,
    input  logic                         data_rdy_i,
    output logic [CNT_WIDTH-1:0]         sym_cnt_o
);

    localparam int unsigned SYM_W  = 3;
    localparam int unsigned BCNT_W = 2;
    localparam logic [2:0]  MODE_QPSK = 3'b001;

    localparam logic signed [DATA_WIDTH-1:0] P256 = DATA_WIDTH'(256);
    localparam logic signed [DATA_WIDTH-1:0] N256 = DATA_WIDTH'(-256);
    localparam logic signed [DATA_WIDTH-1:0] P180 = DATA_WIDTH'(180);
    localparam logic signed [DATA_WIDTH-1:0] N180 = DATA_WIDTH'(-180);
    localparam logic signed [DATA_WIDTH-1:0] P98  = DATA_WIDTH'(98);
    localparam logic signed [DATA_WIDTH-1:0] N98  = DATA_WIDTH'(-98);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    state_t                         state_q, state_d;
    logic [2:0]                     mode_q, mode_d;
    logic [BCNT_W-1:0]              need_q, need_d;
    logic [BCNT_W-1:0]              bit_cnt_q, bit_cnt_d;
    logic [SYM_W-1:0]               sym_q, sym_d;
    logic signed [DATA_WIDTH-1:0]   i_d, q_d;
    logic                           val_d;
    logic [CNT_WIDTH-1:0]           cnt_d;

    logic                           bit_src;
    logic                           bit_valid;
    logic                           bit_accept;
    logic                           completing_bit;
    logic [BCNT_W-1:0]              bit_cnt_inc;

`ifdef PSK_MAPPER_PRBS_SRC_EN
    logic [8:0] prbs_q;
    logic       unused_bit_inputs;

    assign unused_bit_inputs = bit_i ^ bit_val_i;
    assign bit_src           = prbs_q[8];
    assign bit_valid         = 1'b1;

    // PRBS-9 (x^9 + x^5 + 1), advanced only when its MSB is consumed
    always_ff @(posedge clk) begin
        if (reset) begin
            prbs_q <= 9'h1FF;
        end else if (bit_accept) begin
            prbs_q <= {prbs_q[7:0], prbs_q[8] ^ prbs_q[4]};
        end
    end
`else
    assign bit_src   = bit_i;
    assign bit_valid = bit_val_i;
`endif

    // Gray-coded constellation lookup; QPSK uses the two LSBs of the symbol
    function automatic logic [2*DATA_WIDTH-1:0] map_point(input logic is_qpsk,
                                                          input logic [SYM_W-1:0] s);
        logic signed [DATA_WIDTH-1:0] pi;
        logic signed [DATA_WIDTH-1:0] pq;
        pi = P180;
        pq = P180;
        if (is_qpsk) begin
            unique case (s[1:0])
                2'b00:   begin pi = P180; pq = P180; end
                2'b01:   begin pi = N180; pq = P180; end
                2'b11:   begin pi = N180; pq = N180; end
                default: begin pi = P180; pq = N180; end
            endcase
        end else begin
            unique case (s)
                3'b000:  begin pi = P256; pq = P98;  end
                3'b001:  begin pi = P98;  pq = P256; end
                3'b011:  begin pi = N98;  pq = P256; end
                3'b010:  begin pi = N256; pq = P98;  end
                3'b110:  begin pi = N256; pq = N98;  end
                3'b111:  begin pi = N98;  pq = N256; end
                3'b101:  begin pi = P98;  pq = N256; end
                default: begin pi = P256; pq = N98;  end
            endcase
        end
        return {pi, pq};
    endfunction

    // Only the bit that would complete a symbol waits for a full output register
    assign completing_bit = (state_q == COLLECT) && (bit_cnt_q == BCNT_W'(need_q - 2'd1));
    assign bit_rdy_o      = enable_i && !(completing_bit && data_val_o && !data_rdy_i);
    assign bit_accept     = bit_valid && bit_rdy_o;
    assign bit_cnt_inc    = BCNT_W'(bit_cnt_q + 2'd1);

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        need_d    = need_q;
        bit_cnt_d = bit_cnt_q;
        sym_d     = sym_q;
        i_d       = I_data_o;
        q_d       = Q_data_o;
        val_d     = data_val_o;
        cnt_d     = sym_cnt_o;

        if (data_val_o && data_rdy_i) begin
            val_d = 1'b0;
            cnt_d = sym_cnt_o + CNT_WIDTH'(1);
        end

        if (!enable_i) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            sym_d     = '0;
        end else if (bit_accept) begin
            unique case (state_q)
                IDLE: begin
                    mode_d    = mode_i;
                    need_d    = (mode_i == MODE_QPSK) ? 2'd2 : 2'd3;
                    sym_d     = {2'b00, bit_src};
                    bit_cnt_d = 2'd1;
                    state_d   = COLLECT;
                end
                default: begin
                    sym_d     = {sym_q[1:0], bit_src};
                    bit_cnt_d = bit_cnt_inc;
                    if (bit_cnt_inc == need_q) begin
                        {i_d, q_d} = map_point(mode_q == MODE_QPSK, sym_d);
                        val_d      = 1'b1;
                        bit_cnt_d  = '0;
                        state_d    = IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            mode_q     <= '0;
            need_q     <= '0;
            bit_cnt_q  <= '0;
            sym_q      <= '0;
            I_data_o   <= '0;
            Q_data_o   <= '0;
            data_val_o <= 1'b0;
            sym_cnt_o  <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            need_q     <= need_d;
            bit_cnt_q  <= bit_cnt_d;
            sym_q      <= sym_d;
            I_data_o   <= i_d;
            Q_data_o   <= q_d;
            data_val_o <= val_d;
            sym_cnt_o  <= cnt_d;
        end
    end

endmodule

// File: tb/tb_psk_symbol_mapper.sv
// Self-checking bench for psk_symbol_mapper: directed scenarios plus randomized traffic
// compared cycle by cycle against a queue-based constellation model.
module tb_psk_symbol_mapper;

    localparam int unsigned DW = 10;
    localparam int unsigned CW = 16;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [2:0]           mode_i;
    logic                 enable_i;
    logic                 bit_i;
    logic                 bit_val_i;
    logic                 bit_rdy_o;
    logic signed [DW-1:0] I_data_o;
    logic signed [DW-1:0] Q_data_o;
    logic                 data_val_o;
    logic                 data_rdy_i;
    logic [CW-1:0]        sym_cnt_o;

    psk_symbol_mapper #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .mode_i     (mode_i),
        .enable_i   (enable_i),
        .bit_i      (bit_i),
        .bit_val_i  (bit_val_i),
        .bit_rdy_o  (bit_rdy_o),
        .I_data_o   (I_data_o),
        .Q_data_o   (Q_data_o),
        .data_val_o (data_val_o),
        .data_rdy_i (data_rdy_i),
        .sym_cnt_o  (sym_cnt_o)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Constellation points listed in order around the circle (Gray position)
    int qpsk_i[4] = '{180, -180, -180, 180};
    int qpsk_q[4] = '{180, 180, -180, -180};
    int psk8_i[8] = '{256, 98, -98, -256, -256, -98, 98, 256};
    int psk8_q[8] = '{98, 256, 256, 98, -98, -256, -256, -98};

    // Reference model state
    bit       coll[$];
    int       m_need;
    bit       m_val;
    int       m_i, m_q, m_cnt;
    bit [8:0] m_prbs;

    // Symbols handed downstream, captured from the handshake
    int em_i[$];
    int em_q[$];

    task automatic model_reset();
        coll.delete();
        m_need = 0;
        m_val  = 0;
        m_i    = 0;
        m_q    = 0;
        m_cnt  = 0;
        m_prbs = 9'h1FF;
    endtask

    task automatic cycle(input logic en, input logic bv, input logic b,
                         input logic [2:0] md, input logic rdy);
        logic eb, ebv, exp_rdy;
        int   sz, v, pos;
        enable_i   = en;
        bit_val_i  = bv;
        bit_i      = b;
        mode_i     = md;
        data_rdy_i = rdy;
        @(negedge clk);
`ifdef PSK_MAPPER_PRBS_SRC_EN
        eb  = m_prbs[8];
        ebv = 1'b1;
`else
        eb  = b;
        ebv = bv;
`endif
        sz      = coll.size();
        exp_rdy = en && !(sz > 0 && sz == m_need - 1 && m_val && !rdy);
        checks++;
        if (bit_rdy_o !== exp_rdy) begin
            failures++;
            $display("FAIL bit_rdy t=%0t got=%b exp=%b", $time, bit_rdy_o, exp_rdy);
        end
        if (data_val_o === 1'b1 && rdy) begin
            em_i.push_back(int'(I_data_o));
            em_q.push_back(int'(Q_data_o));
        end
        if (m_val && rdy) begin
            m_cnt = (m_cnt + 1) % (1 << CW);
            m_val = 0;
        end
        if (!en) begin
            coll.delete();
        end else if (ebv && exp_rdy) begin
            if (coll.size() == 0) m_need = (md == 3'b001) ? 2 : 3;
            coll.push_back(eb);
            m_prbs = {m_prbs[7:0], m_prbs[8] ^ m_prbs[4]};
            if (coll.size() == m_need) begin
                v = 0;
                foreach (coll[k]) v = v * 2 + int'(coll[k]);
                if (m_need == 2) begin
                    pos = v ^ (v >> 1);
                    m_i = qpsk_i[pos];
                    m_q = qpsk_q[pos];
                end else begin
                    pos = v ^ (v >> 1) ^ (v >> 2);
                    m_i = psk8_i[pos];
                    m_q = psk8_q[pos];
                end
                m_val = 1;
                coll.delete();
            end
        end
        @(posedge clk);
        #1;
        checks++;
        if (data_val_o !== m_val) begin
            failures++;
            $display("FAIL data_val t=%0t got=%b exp=%b", $time, data_val_o, m_val);
        end
        checks++;
        if (int'(I_data_o) !== m_i || int'(Q_data_o) !== m_q) begin
            failures++;
            $display("FAIL iq t=%0t got=(%0d,%0d) exp=(%0d,%0d)", $time,
                     int'(I_data_o), int'(Q_data_o), m_i, m_q);
        end
        checks++;
        if (int'(sym_cnt_o) !== m_cnt) begin
            failures++;
            $display("FAIL sym_cnt t=%0t got=%0d exp=%0d", $time, sym_cnt_o, m_cnt);
        end
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        enable_i   = 1'b1;
        bit_val_i  = 1'b1;
        data_rdy_i = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        em_i.delete();
        em_q.delete();
        checks++;
        if (data_val_o !== 1'b0 || I_data_o !== '0 || Q_data_o !== '0 || sym_cnt_o !== '0) begin
            failures++;
            $display("FAIL reset_state got val=%b i=%0d q=%0d cnt=%0d exp all 0",
                     data_val_o, I_data_o, Q_data_o, sym_cnt_o);
        end
    endtask

    task automatic test_reset();
        do_reset();
        cycle(1'b0, 1'b0, 1'b0, 3'b001, 1'b1);
    endtask

    task automatic test_qpsk();
        logic b[8] = '{0, 0, 0, 1, 1, 1, 1, 0};
        int   ei[4] = '{180, -180, -180, 180};
        int   eq[4] = '{180, 180, -180, -180};
        do_reset();
        foreach (b[k]) cycle(1'b1, 1'b1, b[k], 3'b001, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 3'b001, 1'b1);
        checks++;
        if (sym_cnt_o !== CW'(4)) begin
            failures++;
            $display("FAIL qpsk_count got=%0d exp=4", sym_cnt_o);
        end
`ifndef PSK_MAPPER_PRBS_SRC_EN
        checks++;
        if (em_i.size() != 4) begin
            failures++;
            $display("FAIL qpsk_symbols got=%0d exp=4 symbols", em_i.size());
        end else begin
            foreach (ei[k]) begin
                checks++;
                if (em_i[k] != ei[k] || em_q[k] != eq[k]) begin
                    failures++;
                    $display("FAIL qpsk_sym%0d got=(%0d,%0d) exp=(%0d,%0d)",
                             k, em_i[k], em_q[k], ei[k], eq[k]);
                end
            end
        end
`endif
    endtask

    task automatic test_8psk();
        logic b[6] = '{0, 1, 1, 1, 1, 0};
        int   ei[2] = '{-98, -256};
        int   eq[2] = '{256, -98};
        do_reset();
        foreach (b[k]) cycle(1'b1, 1'b1, b[k], 3'b010, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 3'b010, 1'b1);
`ifndef PSK_MAPPER_PRBS_SRC_EN
        checks++;
        if (em_i.size() != 2) begin
            failures++;
            $display("FAIL psk8_symbols got=%0d exp=2 symbols", em_i.size());
        end else begin
            foreach (ei[k]) begin
                checks++;
                if (em_i[k] != ei[k] || em_q[k] != eq[k]) begin
                    failures++;
                    $display("FAIL psk8_sym%0d got=(%0d,%0d) exp=(%0d,%0d)",
                             k, em_i[k], em_q[k], ei[k], eq[k]);
                end
            end
        end
`endif
    endtask

    task automatic test_backpressure();
        logic b[8] = '{0, 0, 0, 1, 0, 1, 1, 1};
        logic r[8] = '{0, 0, 0, 0, 0, 0, 0, 1};
        do_reset();
        foreach (b[k]) cycle(1'b1, 1'b1, b[k], 3'b000, r[k]);
        cycle(1'b1, 1'b0, 1'b0, 3'b000, 1'b1);
        checks++;
        if (sym_cnt_o !== CW'(2)) begin
            failures++;
            $display("FAIL bp_count got=%0d exp=2", sym_cnt_o);
        end
`ifndef PSK_MAPPER_PRBS_SRC_EN
        checks++;
        if (em_i.size() != 2 || em_i[0] != 256 || em_q[0] != 98 ||
            em_i[1] != 98 || em_q[1] != -256) begin
            failures++;
            $display("FAIL bp_symbols got n=%0d exp (256,98),(98,-256)", em_i.size());
        end
`endif
    endtask

    task automatic test_mode_change();
        do_reset();
        cycle(1'b1, 1'b1, 1'b1, 3'b001, 1'b1);
        cycle(1'b1, 1'b1, 1'b1, 3'b010, 1'b1);
        cycle(1'b1, 1'b1, 1'b0, 3'b010, 1'b1);
        cycle(1'b1, 1'b1, 1'b0, 3'b010, 1'b1);
        cycle(1'b1, 1'b1, 1'b1, 3'b001, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 3'b001, 1'b1);
`ifndef PSK_MAPPER_PRBS_SRC_EN
        checks++;
        if (em_i.size() != 2 || em_i[0] != -180 || em_q[0] != -180 ||
            em_i[1] != 98 || em_q[1] != 256) begin
            failures++;
            $display("FAIL mode_change got n=%0d exp (-180,-180),(98,256)", em_i.size());
        end
`endif
    endtask

    task automatic test_abort();
        do_reset();
        cycle(1'b1, 1'b1, 1'b1, 3'b100, 1'b1);
        cycle(1'b1, 1'b1, 1'b1, 3'b100, 1'b1);
        cycle(1'b0, 1'b1, 1'b1, 3'b100, 1'b1);
        cycle(1'b1, 1'b1, 1'b1, 3'b100, 1'b1);
        cycle(1'b1, 1'b1, 1'b0, 3'b100, 1'b1);
        cycle(1'b1, 1'b1, 1'b0, 3'b100, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 3'b100, 1'b1);
        checks++;
        if (sym_cnt_o !== CW'(1)) begin
            failures++;
            $display("FAIL abort_count got=%0d exp=1", sym_cnt_o);
        end
`ifndef PSK_MAPPER_PRBS_SRC_EN
        checks++;
        if (em_i.size() != 1 || em_i[0] != 256 || em_q[0] != -98) begin
            failures++;
            $display("FAIL abort_symbol got n=%0d exp (256,-98)", em_i.size());
        end
`endif
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        for (int k = 0; k < 6; k++) cycle(1'b1, 1'b1, 1'(k & 1), 3'b011, 1'b0);
        do_reset();
        cycle(1'b1, 1'b0, 1'b0, 3'b011, 1'b1);
    endtask

    task automatic test_random();
        logic [2:0] md;
        do_reset();
        for (int k = 0; k < 1500; k++) begin
            md = ($urandom_range(0, 1) == 1) ? 3'b001 : 3'($urandom_range(0, 7));
            cycle(1'($urandom_range(0, 19) != 0), 1'($urandom_range(0, 4) != 0),
                  1'($urandom), md, 1'($urandom_range(0, 9) < 7));
        end
    endtask

    initial begin
        reset      = 1'b1;
        mode_i     = 3'b001;
        enable_i   = 1'b0;
        bit_i      = 1'b0;
        bit_val_i  = 1'b0;
        data_rdy_i = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_qpsk();
        test_8psk();
        test_backpressure();
        test_mode_change();
        test_abort();
        test_reset_mid_stall();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
